// File: rtl/bcd_tick_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_tick_counter_pkg
// Description : Shared types and constants for the BCD tick counter: FSM
//               state encoding and the 16-entry active-low 7-segment table
//               (bit order {g,f,e,d,c,b,a}).
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_tick_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Index = nibble value; 10..15 are not decimal digits and show blank.
  localparam logic [6:0] c_seg_code [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b1111111,  // 10
    7'b1111111,  // 11
    7'b1111111,  // 12
    7'b1111111,  // 13
    7'b1111111,  // 14
    7'b1111111   // 15
  };

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decoder
// Description : One-digit BCD to active-low 7-segment decoder.
// Ports       : digit  in  4  BCD nibble
//               seg_n  out 7  segments {g,f,e,d,c,b,a}, 0 = lit
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
  import bcd_tick_counter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  assign seg_n = c_seg_code[digit];

endmodule
`default_nettype wire

// File: rtl/bcd_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_tick_counter
// Description : Samples a slow divided clock as data, detects its rising
//               edges and advances a DIGITS-wide BCD counter once per edge
//               while running. Controlled by start/stop/clear; drives
//               active-low 7-segment displays.
// Ports       : clk          in   1         system clock
//               reset        in   1         synchronous active-high reset
//               slow_clk_in  in   1         slow clock, treated as data
//               start        in   1         begin/resume counting (level)
//               stop         in   1         freeze count (level)
//               clear        in   1         zero count and go idle (level)
//               bcd          out  4*DIGITS  count, digit 0 in bits [3:0]
//               running      out  1         high while in RUN
//               rollover     out  1         1-cycle pulse on all-9s -> 0 wrap
//               hex_n        out  7*DIGITS  active-low segments per digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_tick_counter
  import bcd_tick_counter_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slow_clk_in,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  rollover,
  output logic [7*DIGITS-1:0]   hex_n
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_prev_q, sync_prev_d;
  logic                   tick;
  state_t                 state_q, state_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d, bcd_inc;
  logic                   all_nines;
  logic                   running_q, running_d;
  logic                   rollover_q, rollover_d;

  // Synchroniser shift chain plus one history flop for edge detection.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], slow_clk_in};
    sync_prev_d = sync_q[SYNC_STAGES-1];
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // Ripple BCD increment: the carry propagates through digits sitting at 9.
  // A carry surviving past the top digit means the count was all nines.
  always_comb begin
    logic carry;
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  // Control: clear beats stop beats start. A tick is only accepted while the
  // current state is RUN, so a tick alongside the stop that leaves RUN still
  // counts, while one alongside the start that enters RUN does not.
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    rollover_d = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      bcd_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bcd_d = '0;
          if (start && !stop) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (tick) begin
            bcd_d      = bcd_inc;
            rollover_d = all_nines;
          end
          if (stop) state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (start && !stop) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          bcd_d   = '0;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      bcd_q       <= '0;
      running_q   <= 1'b0;
      rollover_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sync_prev_q <= sync_prev_d;
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      running_q   <= running_d;
      rollover_q  <= rollover_d;
    end
  end

  assign bcd      = bcd_q;
  assign running  = running_q;
  assign rollover = rollover_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decoder u_dec (
      .digit (bcd_q[4*g +: 4]),
      .seg_n (hex_n[7*g +: 7])
    );
  end

endmodule
`default_nettype wire
